// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Operands are latched at launch; the result is formed from the latched copies and written at commit.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_D,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt, cnt_nx;
    logic [31:0] op_a, op_b;
    logic [1:0]  op_sel;
    logic        launch, commit;

    logic [63:0] prod;
    logic        neg_a, neg_b;
    logic [31:0] mag_a, mag_b, divisor;
    logic [31:0] q_mag, r_mag, quot, rem;

    assign launch   = start && (state == IDLE) && !md_op[2];
    assign commit   = (state == BUSY) && (cnt == 5'd1);
    assign busy     = (state == BUSY);
    assign md_stall = md_use_D && (busy || (start && !md_op[2]));

    // Signed ops use sign-extended operands; the low 64 bits of the product are exact either way.
    always_comb begin
        prod = {{32{!op_sel[0] & op_a[31]}}, op_a} * {{32{!op_sel[0] & op_b[31]}}, op_b};
    end

    // Signed division on magnitudes: avoids the 0x80000000 / -1 overflow and truncates toward zero.
    always_comb begin
        neg_a   = !op_sel[0] && op_a[31];
        neg_b   = !op_sel[0] && op_b[31];
        mag_a   = neg_a ? (32'd0 - op_a) : op_a;
        mag_b   = neg_b ? (32'd0 - op_b) : op_b;
        divisor = (op_b == '0) ? 32'd1 : mag_b;
        q_mag   = mag_a / divisor;
        r_mag   = mag_a % divisor;
        quot    = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
        rem     = neg_a ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (launch) begin
                    state_nx = BUSY;
                    cnt_nx   = md_op[1] ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
                end
            end
            BUSY: begin
                cnt_nx = cnt - 5'd1;
                if (cnt == 5'd1) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            op_sel <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (launch) begin
                op_a   <= a;
                op_b   <= b;
                op_sel <= md_op[1:0];
            end
            if (commit) begin
                if (!op_sel[1]) begin
                    {hi, lo} <= prod;
                end else if (op_b != '0) begin
                    hi <= rem;
                    lo <= quot;
                end
            end else if (start && (state == IDLE)) begin
                if (md_op == 3'b100) begin
                    hi <= a;
                end else if (md_op == 3'b101) begin
                    lo <= a;
                end
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Randomized self-checking bench for md_unit against an arithmetic reference model.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a, b;
    logic        md_use_D;
    logic        busy, md_stall;
    logic [31:0] hi, lo;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
        .md_use_D(md_use_D), .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int cycles_for(input logic [2:0] op);
        if (op <= 3'd1) return 5;
        if (op <= 3'd3) return 10;
        return 0;
    endfunction

    // Reference: architectural HI/LO after the operation, from plain integer arithmetic.
    function automatic void model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                  input logic [31:0] oh, input logic [31:0] ol,
                                  output logic [31:0] nh, output logic [31:0] nl);
        longint sa, sb, q, r;
        logic [63:0] p;
        nh = oh;
        nl = ol;
        sa = longint'($signed(x));
        sb = longint'($signed(y));
        case (op)
            3'd0: begin p = 64'(sa * sb); nh = p[63:32]; nl = p[31:0]; end
            3'd1: begin p = {32'd0, x} * {32'd0, y}; nh = p[63:32]; nl = p[31:0]; end
            3'd2: if (y != 0) begin q = sa / sb; r = sa % sb; nl = q[31:0]; nh = r[31:0]; end
            3'd3: if (y != 0) begin nl = x / y; nh = x % y; end
            3'd4: nh = x;
            3'd5: nl = x;
            default: ;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic use_d, input logic inject);
        int n;
        logic [31:0] nh, nl;
        n = cycles_for(op);
        model(op, x, y, exp_hi, exp_lo, nh, nl);
        @(negedge clk);
        start = 1'b1; md_op = op; a = x; b = y; md_use_D = use_d;
        #1;
        check("stall_at_start", md_stall, use_d && (op <= 3'd3));
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= n; k++) begin
            a = $urandom;
            b = $urandom;
            if (inject && k == 2) begin
                start = 1'b1;
                md_op = 3'($urandom_range(0, 5));
            end
            #1;
            check("busy_high", busy, 1'b1);
            check("stall_busy", md_stall, use_d);
            check("hi_hold", hi, exp_hi);
            check("lo_hold", lo, exp_lo);
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        check("busy_low", busy, 1'b0);
        check("stall_low", md_stall, 1'b0);
        check("hi_result", hi, nh);
        check("lo_result", lo, nl);
        exp_hi = nh;
        exp_lo = nl;
    endtask

    task automatic mid_op_reset();
        @(negedge clk);
        start = 1'b1; md_op = 3'd0; a = 32'h0000_1234; b = 32'h0000_5678; md_use_D = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        exp_hi = '0;
        exp_lo = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            check("post_rst_busy", busy, 1'b0);
            check("post_rst_hilo", {hi, lo}, 64'h0);
        end
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        reset = 1'b0; start = 1'b0; md_op = '0; a = '0; b = '0; md_use_D = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        reset = 1'b1;

        run_op(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 1'b0);
        check("mult_neg_hi", hi, 32'hFFFF_FFFF);
        check("mult_neg_lo", lo, 32'hFFFF_FFFA);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b0);
        check("div_neg7", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(3'd4, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
        run_op(3'd5, 32'h9ABC_DEF0, 32'h0, 1'b1, 1'b0);
        check("mthi_mtlo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
        run_op(3'd3, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0);
        check("divu_by_zero", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
        run_op(3'd6, 32'h1111_1111, 32'h2, 1'b1, 1'b0);
        run_op(3'd7, 32'h2222_2222, 32'h3, 1'b0, 1'b0);
        check("noop_keep", {hi, lo}, 64'h1234_5678_9ABC_DEF0);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($signed(4'($urandom_range(0, 15))));
            run_op(rop, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        mid_op_reset();
        run_op(3'd3, 32'd100, 32'd7, 1'b0, 1'b0);
        check("divu_after_rst", {hi, lo}, {32'd2, 32'd14});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers in the E stage of the 5-stage MIPS pipeline.
- Executes mult, multu, div, divu, mthi and mtlo.
- Drives busy and md_stall, which the hazard unit ORs into stall_F, stall_D and flush_E.
- mfhi and mflo read hi and lo directly in E through the normal E-stage result path.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (valid 1..31)
- DIV_CYCLES, 10, busy cycles for div/divu (valid 1..31)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- start  input  1  one-cycle pulse while an md instruction is in E and not flushed
- md_op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 are no-op
- a  input  32  forwarded rs_E value
- b  input  32  forwarded rt_E value
- md_use_D  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  output  1  multi-cycle operation in progress
- md_stall  output  1  stall request to the hazard unit
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset: sampled on the rising clk edge while reset==0.
  - busy=0, hi=0, lo=0, internal counter=0, state=IDLE.
  - Reset asserted mid-operation discards the pending result. HI/LO are not written by it.
- States:
  - IDLE → BUSY on start with md_op in {000..011}; counter loads MULT_CYCLES or DIV_CYCLES.
  - BUSY: counter decrements each cycle. When counter==1, the edge commits the result to hi/lo and the state returns to IDLE.
- Latency: start sampled in cycle t.
  - busy is high in cycles t+1 .. t+N, where N is the selected parameter.
  - New hi/lo are visible from cycle t+N+1.
  - busy is a registered output.
- Operand capture: a and b are latched at the start edge. Later changes on a/b have no effect.
- Result timing: the result may be computed at capture or at commit. Only the commit-time visibility of hi/lo is architectural.
- mult: {hi,lo} = signed(a) * signed(b), 64-bit.
- multu: {hi,lo} = unsigned(a) * unsigned(b), 64-bit.
- div: lo = signed quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
  - a=0x80000000, b=0xFFFFFFFF gives lo=0x80000000, hi=0x00000000.
- divu: lo = a/b, hi = a%b (unsigned).
- Divide by zero (b==0 for div/divu): the unit still goes busy for DIV_CYCLES, but hi and lo keep their previous values.
- mthi / mtlo: when start is high in IDLE, hi<=a (or lo<=a) at that edge. busy is not asserted.
- Ignored starts (hi/lo unchanged, no state change):
  - start while in BUSY. The hazard unit guarantees this does not happen.
  - md_op 110/111.
- md_stall = md_use_D && (busy || (start && md_op in {000..011})). This output is combinational.
  - Any md instruction in D is held until the cycle after busy drops.
  - mfhi/mflo therefore always read committed values.
- Simultaneous commit and start in the same cycle cannot occur, because busy is still high then. That start is treated as "start while in BUSY".
- hi and lo only change at a commit edge, an mthi/mtlo edge, or reset.

Test Plan:
- Reset, then mult a=0xFFFFFFFE (-2), b=0x00000003 → busy high cycles t+1..t+5; hi=0xFFFFFFFF, lo=0xFFFFFFFA at t+6.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
- Signed div:
  - a=0xFFFFFFF9 (-7), b=2 → busy t+1..t+10; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- mthi a=0x12345678, then next cycle mtlo a=0x9ABCDEF0 → hi and lo updated one edge after each start, with busy never high. Then divu b=0 → busy 10 cycles, hi/lo unchanged.
- Stall and ignored start:
  - During div, md_use_D=1 → md_stall high from the start cycle through t+10, low at t+11.
  - md_use_D=0 → md_stall stays 0.
  - A start pulse injected mid-busy → ignored, result unchanged.
- Reset mid-operation: reset=0 at cycle t+3 of a mult → busy=0, hi=lo=0 next cycle. No later commit occurs.
